dbg_io_ctrl: RTL and testbench
==============================

# dbg_io_ctrl

Host-facing debug controller: the initiator for the external (`ext_*`) side of the CPU state multiplexer. It accepts one debug command at a time from the host link and halts the core. It then drives the `debug` mode code and performs a single icache read or write, regfile port-2 read, or dcache read. Read data is returned on a valid/ready response channel. It sits between the board I/O logic and `cpu_state_mux`/the core halt logic.

## Interface
- `DEBUG_WIDTH`, `IADDR_WIDTH`, `RADDR_WIDTH`, `DADDR_WIDTH`, `DATA_WIDTH`: from `define.vh` (not overridable). Mode codes are `` `DEBUG_NONE ``, `` `DEBUG_ICRD ``, `` `DEBUG_ICWR ``, `` `DEBUG_REGRD ``, `` `DEBUG_DCRD ``.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: async active-low reset
- `cmd_valid` in 1: host command valid
- `cmd_ready` out 1: high only in IDLE
- `cmd_op` in 2: 0=ICRD, 1=ICWR, 2=REGRD, 3=DCRD
- `cmd_addr` in DATA_WIDTH: target address, low bits used per target
- `cmd_wdata` in DATA_WIDTH: icache write data (ICWR only)
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: host accepts response
- `rsp_rdata` out DATA_WIDTH: read data (0 for ICWR)
- `halt_req` out 1: request core stall
- `halt_ack` in 1: core drained and stalled
- `debug` out DEBUG_WIDTH: mode code to mux and core
- `ext_icache_ceb`, `ext_icache_web` out 1 each: active-low chip/write enable
- `ext_icache_addr` out IADDR_WIDTH
- `ext_icache_wdata` out DATA_WIDTH
- `icache_rdata` in DATA_WIDTH: icache read data
- `ext_reg_read2` out 1: active-high read strobe
- `ext_reg_rs2` out RADDR_WIDTH
- `reg_rdata2` in DATA_WIDTH: regfile port-2 data
- `ext_dcache_ceb`, `ext_dcache_web` out 1 each: active-low
- `ext_dcache_bweb` out DATA_WIDTH: active-low bit write enable
- `ext_dcache_addr` out DADDR_WIDTH
- `dcache_rdata` in DATA_WIDTH

## Operation
- Reset values:
  - state IDLE, `debug=DEBUG_NONE`, `halt_req=0`, `rsp_valid=0`, `rsp_rdata=0`.
  - All ceb/web=1, `ext_dcache_bweb` all ones, `ext_reg_read2=0`.
  - All addr and wdata = 0, `cmd_ready=1`.
- FSM states: IDLE, HALT, ACCESS, CAPTURE, RESP.
- IDLE: on `cmd_valid & cmd_ready`, register op, addr (truncated to target width, LSBs), and wdata. Go to HALT.
- HALT:
  - Assert `halt_req`; drive `debug` with the op's mode code.
  - All strobes stay inactive so the mux switches before any access.
  - Remain until `halt_ack=1`, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - ICRD: `ext_icache_ceb=0`, `web=1`.
  - ICWR: `ceb=0`, `web=0`, `wdata` driven.
  - REGRD: `ext_reg_read2=1`.
  - DCRD: `ext_dcache_ceb=0`, `web=1`, `bweb` all ones.
  - Address is held stable through HALT, ACCESS and CAPTURE.
  - Reads go to CAPTURE; ICWR goes to RESP.
- CAPTURE (1 cycle):
  - Strobes are inactive.
  - `rsp_rdata` latches the selected read data (`icache_rdata`, `reg_rdata2` or `dcache_rdata`). All targets are treated as 1-cycle synchronous read.
  - Go to RESP.
- RESP:
  - `rsp_valid=1`; `rsp_rdata` is stable; `debug` and `halt_req` are held.
  - On `rsp_ready`, go to IDLE. `debug=DEBUG_NONE` and `halt_req=0` take effect from the next cycle.
  - ICWR responds with `rsp_rdata=0`.
- The dcache is never written by this block: `ext_dcache_web` and `bweb` stay inactive always.
- Commands presented outside IDLE are not accepted (`cmd_ready=0`). The host holds them.
- Reset mid-operation aborts immediately to reset values, with no partial write. An ICWR already strobed in ACCESS is complete.
- `halt_ack` dropping after HALT is ignored; `halt_req` stays high until return to IDLE.

## Timing
- Command accepted at edge T gives HALT in cycle T+1.
- With `halt_ack` already high: ACCESS at T+2, CAPTURE at T+3, `rsp_valid` at T+4.
- Read latency is therefore 4 cycles minimum from accept to response; write latency is 3.
- Each cycle `halt_ack` is low in HALT adds one cycle.
- `rsp_valid` with `rsp_ready` already high lasts 1 cycle. The next command can be accepted at the edge after return to IDLE, i.e. one idle cycle minimum between commands.
- Strobes are registered outputs (glitch-free), one cycle wide, never two accesses per command.

## Test plan
- Reset: hold `rst_n=0` mid-clock. All outputs at the reset values above, asynchronously, before the next edge.
- ICWR addr=0x10, wdata=0xDEADBEEF, `halt_ack` tied 1:
  - `debug=DEBUG_ICWR` from T+1.
  - `ext_icache_ceb=0`, `web=0` only at T+2, with addr 0x10 and data 0xDEADBEEF.
  - `rsp_valid` at T+3, `rdata=0`.
- ICRD addr=0x10 with an icache model returning 0xDEADBEEF: single ceb pulse at T+2, `rsp_rdata=0xDEADBEEF` valid at T+4.
- REGRD rs2=5 with `halt_ack` delayed 3 cycles:
  - `halt_req=1` and `debug=DEBUG_REGRD` from T+1.
  - `ext_reg_read2` pulse at T+5; model value 0x1234 returned at T+7.
- DCRD with `rsp_ready` low for 4 cycles:
  - `rsp_valid` and data held stable throughout; `cmd_ready=0`.
  - A second `cmd_valid` is not accepted until after `rsp_ready`.
  - `debug` returns to NONE one cycle after the response handshake.
- Reset asserted during HALT of an ICWR: no icache write strobe ever seen, FSM in IDLE after release, next command completes normally.

Source files
------------

// File: rtl/dbg_io_ctrl.sv
// Host debug controller: halts the core, performs one icache/regfile/dcache access
// through the external port of the CPU state mux, and returns read data to the host.

package dbg_io_pkg;
    localparam int DEBUG_WIDTH = 3;
    localparam int IADDR_WIDTH = 10;
    localparam int RADDR_WIDTH = 5;
    localparam int DADDR_WIDTH = 10;
    localparam int DATA_WIDTH  = 32;

    localparam logic [DEBUG_WIDTH-1:0] DEBUG_NONE  = 3'd0;
    localparam logic [DEBUG_WIDTH-1:0] DEBUG_ICRD  = 3'd1;
    localparam logic [DEBUG_WIDTH-1:0] DEBUG_ICWR  = 3'd2;
    localparam logic [DEBUG_WIDTH-1:0] DEBUG_REGRD = 3'd3;
    localparam logic [DEBUG_WIDTH-1:0] DEBUG_DCRD  = 3'd4;

    typedef enum logic [1:0] {
        OP_ICRD  = 2'd0,
        OP_ICWR  = 2'd1,
        OP_REGRD = 2'd2,
        OP_DCRD  = 2'd3
    } op_e;
endpackage

module dbg_io_ctrl
    import dbg_io_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [DATA_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   halt_req,
    input  logic                   halt_ack,
    output logic [DEBUG_WIDTH-1:0] debug,
    output logic                   ext_icache_ceb,
    output logic                   ext_icache_web,
    output logic [IADDR_WIDTH-1:0] ext_icache_addr,
    output logic [DATA_WIDTH-1:0]  ext_icache_wdata,
    input  logic [DATA_WIDTH-1:0]  icache_rdata,
    output logic                   ext_reg_read2,
    output logic [RADDR_WIDTH-1:0] ext_reg_rs2,
    input  logic [DATA_WIDTH-1:0]  reg_rdata2,
    output logic                   ext_dcache_ceb,
    output logic                   ext_dcache_web,
    output logic [DATA_WIDTH-1:0]  ext_dcache_bweb,
    output logic [DADDR_WIDTH-1:0] ext_dcache_addr,
    input  logic [DATA_WIDTH-1:0]  dcache_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_e;

    state_e                 state_q,     state_d;
    op_e                    op_q,        op_d;
    logic [IADDR_WIDTH-1:0] iaddr_q,     iaddr_d;
    logic [RADDR_WIDTH-1:0] raddr_q,     raddr_d;
    logic [DADDR_WIDTH-1:0] daddr_q,     daddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q,     wdata_d;
    logic [DEBUG_WIDTH-1:0] debug_q,     debug_d;
    logic                   halt_req_q,  halt_req_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   ic_ceb_q,    ic_ceb_d;
    logic                   ic_web_q,    ic_web_d;
    logic                   reg_rd_q,    reg_rd_d;
    logic                   dc_ceb_q,    dc_ceb_d;

    // Upper command address bits are deliberately ignored by every target.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cmd_addr[DATA_WIDTH-1:IADDR_WIDTH];

    function automatic logic [DEBUG_WIDTH-1:0] mode_code(input op_e op);
        logic [DEBUG_WIDTH-1:0] code;
        case (op)
            OP_ICRD:  code = DEBUG_ICRD;
            OP_ICWR:  code = DEBUG_ICWR;
            OP_REGRD: code = DEBUG_REGRD;
            OP_DCRD:  code = DEBUG_DCRD;
        endcase
        return code;
    endfunction

    assign cmd_ready = (state_q == S_IDLE);

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        op_d        = op_q;
        iaddr_d     = iaddr_q;
        raddr_d     = raddr_q;
        daddr_d     = daddr_q;
        wdata_d     = wdata_q;
        debug_d     = debug_q;
        halt_req_d  = halt_req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        ic_ceb_d    = 1'b1;
        ic_web_d    = 1'b1;
        reg_rd_d    = 1'b0;
        dc_ceb_d    = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = op_e'(cmd_op);
                    iaddr_d    = cmd_addr[IADDR_WIDTH-1:0];
                    raddr_d    = cmd_addr[RADDR_WIDTH-1:0];
                    daddr_d    = cmd_addr[DADDR_WIDTH-1:0];
                    wdata_d    = cmd_wdata;
                    debug_d    = mode_code(op_e'(cmd_op));
                    halt_req_d = 1'b1;
                    state_d    = S_HALT;
                end
            end

            S_HALT: begin
                // Strobes are launched from here so they are registered and live only in ACCESS.
                if (halt_ack) begin
                    state_d = S_ACCESS;
                    case (op_q)
                        OP_ICRD:  ic_ceb_d = 1'b0;
                        OP_ICWR: begin
                            ic_ceb_d = 1'b0;
                            ic_web_d = 1'b0;
                        end
                        OP_REGRD: reg_rd_d = 1'b1;
                        OP_DCRD:  dc_ceb_d = 1'b0;
                    endcase
                end
            end

            S_ACCESS: begin
                if (op_q == OP_ICWR) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                case (op_q)
                    OP_ICRD:  rsp_rdata_d = icache_rdata;
                    OP_REGRD: rsp_rdata_d = reg_rdata2;
                    OP_DCRD:  rsp_rdata_d = dcache_rdata;
                    OP_ICWR:  rsp_rdata_d = '0;
                endcase
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    debug_d     = DEBUG_NONE;
                    halt_req_d  = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ICRD;
            iaddr_q     <= '0;
            raddr_q     <= '0;
            daddr_q     <= '0;
            wdata_q     <= '0;
            debug_q     <= DEBUG_NONE;
            halt_req_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ic_ceb_q    <= 1'b1;
            ic_web_q    <= 1'b1;
            reg_rd_q    <= 1'b0;
            dc_ceb_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            op_q        <= op_d;
            iaddr_q     <= iaddr_d;
            raddr_q     <= raddr_d;
            daddr_q     <= daddr_d;
            wdata_q     <= wdata_d;
            debug_q     <= debug_d;
            halt_req_q  <= halt_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ic_ceb_q    <= ic_ceb_d;
            ic_web_q    <= ic_web_d;
            reg_rd_q    <= reg_rd_d;
            dc_ceb_q    <= dc_ceb_d;
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign halt_req         = halt_req_q;
    assign debug            = debug_q;
    assign ext_icache_ceb   = ic_ceb_q;
    assign ext_icache_web   = ic_web_q;
    assign ext_icache_addr  = iaddr_q;
    assign ext_icache_wdata = wdata_q;
    assign ext_reg_read2    = reg_rd_q;
    assign ext_reg_rs2      = raddr_q;
    assign ext_dcache_ceb   = dc_ceb_q;
    assign ext_dcache_addr  = daddr_q;

    // The dcache is read-only from the debug side.
    assign ext_dcache_web   = 1'b1;
    assign ext_dcache_bweb  = '1;

endmodule

// File: tb/tb_dbg_io_ctrl.sv
// Self-checking bench for dbg_io_ctrl: directed test-plan steps followed by random commands,
// each checked against expected memory contents and the command latency rules.

module tb_dbg_io_ctrl;
    import dbg_io_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [DATA_WIDTH-1:0]  cmd_addr;
    logic [DATA_WIDTH-1:0]  cmd_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_rdata;
    logic                   halt_req;
    logic                   halt_ack;
    logic [DEBUG_WIDTH-1:0] debug;
    logic                   ext_icache_ceb;
    logic                   ext_icache_web;
    logic [IADDR_WIDTH-1:0] ext_icache_addr;
    logic [DATA_WIDTH-1:0]  ext_icache_wdata;
    logic [DATA_WIDTH-1:0]  icache_rdata;
    logic                   ext_reg_read2;
    logic [RADDR_WIDTH-1:0] ext_reg_rs2;
    logic [DATA_WIDTH-1:0]  reg_rdata2;
    logic                   ext_dcache_ceb;
    logic                   ext_dcache_web;
    logic [DATA_WIDTH-1:0]  ext_dcache_bweb;
    logic [DADDR_WIDTH-1:0] ext_dcache_addr;
    logic [DATA_WIDTH-1:0]  dcache_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dbg_io_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .halt_req         (halt_req),
        .halt_ack         (halt_ack),
        .debug            (debug),
        .ext_icache_ceb   (ext_icache_ceb),
        .ext_icache_web   (ext_icache_web),
        .ext_icache_addr  (ext_icache_addr),
        .ext_icache_wdata (ext_icache_wdata),
        .icache_rdata     (icache_rdata),
        .ext_reg_read2    (ext_reg_read2),
        .ext_reg_rs2      (ext_reg_rs2),
        .reg_rdata2       (reg_rdata2),
        .ext_dcache_ceb   (ext_dcache_ceb),
        .ext_dcache_web   (ext_dcache_web),
        .ext_dcache_bweb  (ext_dcache_bweb),
        .ext_dcache_addr  (ext_dcache_addr),
        .dcache_rdata     (dcache_rdata)
    );

    function automatic logic [31:0] ic_init(input int i);
        return (32'(i) * 32'h0100_0193) ^ 32'hC0FF_EE00;
    endfunction

    function automatic logic [31:0] reg_val(input logic [4:0] i);
        return (i == 5'd5) ? 32'h0000_1234 : (32'hA5A5_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] dc_val(input logic [9:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Target models: 1-cycle synchronous reads; read data is junk in cycles without a read.
    logic [31:0] imem [1024];
    logic [31:0] exp_imem [1024];
    logic        imem_ready = 1'b0;
    int          ic_wr_total = 0;

    always @(posedge clk) begin
        icache_rdata <= $urandom;
        reg_rdata2   <= $urandom;
        dcache_rdata <= $urandom;
        if (!imem_ready) begin
            for (int i = 0; i < 1024; i++) imem[i] <= ic_init(i);
            imem_ready <= 1'b1;
        end else if (ext_icache_ceb === 1'b0) begin
            if (ext_icache_web === 1'b0) begin
                imem[ext_icache_addr] <= ext_icache_wdata;
                ic_wr_total <= ic_wr_total + 1;
            end else begin
                icache_rdata <= imem[ext_icache_addr];
            end
        end
        if (ext_reg_read2 === 1'b1) reg_rdata2 <= reg_val(ext_reg_rs2);
        if (ext_dcache_ceb === 1'b0) dcache_rdata <= dc_val(ext_dcache_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_halt_req"}, 32'(halt_req), 32'd0);
        check({tag, "_debug"}, 32'(debug), 32'(DEBUG_NONE));
        check({tag, "_ic_ceb_web"}, 32'({ext_icache_ceb, ext_icache_web}), 32'd3);
        check({tag, "_ic_addr"}, 32'(ext_icache_addr), 32'd0);
        check({tag, "_ic_wdata"}, ext_icache_wdata, 32'd0);
        check({tag, "_reg_read2"}, 32'(ext_reg_read2), 32'd0);
        check({tag, "_reg_rs2"}, 32'(ext_reg_rs2), 32'd0);
        check({tag, "_dc_ceb_web"}, 32'({ext_dcache_ceb, ext_dcache_web}), 32'd3);
        check({tag, "_dc_bweb"}, ext_dcache_bweb, 32'hFFFF_FFFF);
        check({tag, "_dc_addr"}, 32'(ext_dcache_addr), 32'd0);
    endtask

    // Issues one command starting at a negedge in IDLE; returns at the negedge after the handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_dly, input int rdy_dly, input bit keep_valid, input bit rand_ack);
        logic [31:0] exp_rd;
        logic [31:0] exp_addr;
        logic [31:0] exp_mode;
        logic [31:0] strobe_addr  = '0;
        logic [31:0] strobe_wdata = '0;
        int ic_n = 0, icw_n = 0, rd_n = 0, dc_n = 0;
        int acc_k = -1, rsp_k = -1, vcnt = 0;
        bit hs_pending = 0, done = 0;

        case (op)
            2'd0: begin exp_rd = exp_imem[addr[9:0]]; exp_addr = 32'(addr[9:0]); exp_mode = 32'(DEBUG_ICRD);  end
            2'd1: begin exp_rd = 32'd0;               exp_addr = 32'(addr[9:0]); exp_mode = 32'(DEBUG_ICWR);  end
            2'd2: begin exp_rd = reg_val(addr[4:0]);  exp_addr = 32'(addr[4:0]); exp_mode = 32'(DEBUG_REGRD); end
            default: begin exp_rd = dc_val(addr[9:0]); exp_addr = 32'(addr[9:0]); exp_mode = 32'(DEBUG_DCRD); end
        endcase

        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        halt_ack  = (ack_dly == 0);
        rsp_ready = (rdy_dly == 0);
        if (op == 2'd1) exp_imem[addr[9:0]] = wdata;

        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (!keep_valid) cmd_valid = 1'b0;
            if (hs_pending) begin
                check("post_rsp_valid", 32'(rsp_valid), 32'd0);
                check("post_debug", 32'(debug), 32'(DEBUG_NONE));
                check("post_halt_req", 32'(halt_req), 32'd0);
                check("post_cmd_ready", 32'(cmd_ready), 32'd1);
                done = 1;
            end else begin
                check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
                check("busy_halt_req", 32'(halt_req), 32'd1);
                check("busy_debug", 32'(debug), exp_mode);
                check("dc_web", 32'(ext_dcache_web), 32'd1);
                check("dc_bweb", ext_dcache_bweb, 32'hFFFF_FFFF);
                if (rsp_k < 0) begin
                    case (op)
                        2'd0, 2'd1: check("ic_addr_stable", 32'(ext_icache_addr), exp_addr);
                        2'd2:       check("rs2_stable", 32'(ext_reg_rs2), exp_addr);
                        default:    check("dc_addr_stable", 32'(ext_dcache_addr), exp_addr);
                    endcase
                end
                if (ext_icache_ceb === 1'b0) begin
                    ic_n++;
                    if (acc_k < 0) acc_k = k;
                    if (ext_icache_web === 1'b0) icw_n++;
                    strobe_addr  = 32'(ext_icache_addr);
                    strobe_wdata = ext_icache_wdata;
                end
                if (ext_reg_read2 === 1'b1) begin
                    rd_n++;
                    if (acc_k < 0) acc_k = k;
                    strobe_addr = 32'(ext_reg_rs2);
                end
                if (ext_dcache_ceb === 1'b0) begin
                    dc_n++;
                    if (acc_k < 0) acc_k = k;
                    strobe_addr = 32'(ext_dcache_addr);
                end
                if (rsp_valid === 1'b1) begin
                    if (rsp_k < 0) rsp_k = k;
                    vcnt++;
                    check("rsp_rdata", rsp_rdata, exp_rd);
                    if (vcnt > rdy_dly) rsp_ready = 1'b1;
                    hs_pending = rsp_ready;
                end
                halt_ack = (k > ack_dly);
                if (rand_ack && k > ack_dly + 1) halt_ack = 1'($urandom_range(0, 1));
            end
        end

        check("cmd_completed", 32'(done), 32'd1);
        check("access_cycle", 32'(acc_k), 32'(2 + ack_dly));
        check("rsp_latency", 32'(rsp_k), 32'((op == 2'd1) ? 3 + ack_dly : 4 + ack_dly));
        check("rsp_valid_len", 32'(vcnt), 32'(rdy_dly + 1));
        check("ic_strobes", 32'(ic_n), 32'((op == 2'd0 || op == 2'd1) ? 1 : 0));
        check("ic_writes", 32'(icw_n), 32'((op == 2'd1) ? 1 : 0));
        check("reg_strobes", 32'(rd_n), 32'((op == 2'd2) ? 1 : 0));
        check("dc_strobes", 32'(dc_n), 32'((op == 2'd3) ? 1 : 0));
        check("strobe_addr", strobe_addr, exp_addr);
        if (op == 2'd1) check("strobe_wdata", strobe_wdata, wdata);
        rsp_ready = 1'b1;
    endtask

    initial begin
        int wr_base;
        logic [1:0]  r_op;
        logic [31:0] r_addr;

        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        halt_ack  = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 1024; i++) exp_imem[i] = ic_init(i);

        // Reset asserted before any clock edge must take effect immediately.
        #1 rst_n = 1'b0;
        #2 check_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_cmd(2'd1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
        do_cmd(2'd0, 32'h0000_0010, 32'h0,         0, 0, 1'b0, 1'b0);
        do_cmd(2'd2, 32'h0000_0005, 32'h0,         3, 0, 1'b0, 1'b0);
        do_cmd(2'd3, 32'h0000_002A, 32'h0,         0, 4, 1'b1, 1'b0);
        do_cmd(2'd0, 32'hFFFF_FC10, 32'h0,         1, 1, 1'b0, 1'b1);

        // Reset during HALT of an ICWR: the write must never be strobed.
        wr_base   = ic_wr_total;
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_addr  = 32'h0000_0010;
        cmd_wdata = 32'h0BAD_F00D;
        halt_ack  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_halt_req", 32'(halt_req), 32'd1);
        check("abort_debug", 32'(debug), 32'(DEBUG_ICWR));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("abort");
        halt_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_no_write", 32'(ic_wr_total), 32'(wr_base));
        check("abort_idle", 32'(cmd_ready), 32'd1);
        do_cmd(2'd0, 32'h0000_0010, 32'h0, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
            do_cmd(r_op, r_addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
